spi_slave_ctrl_burst: RTL and testbench

//  Parametrised SPI slave transaction controller driving the shift register, address latch and data memory.

---
 rtl/spi_slave_ctrl_burst_pkg.sv | 28 ++
 rtl/spi_slave_ctrl_burst_sclk_edge_detect.sv | 32 +++
 rtl/spi_slave_ctrl_burst.sv | 125 ++++++++++++
 tb/tb_spi_slave_ctrl_burst.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_slave_ctrl_burst_pkg.sv
// Shared definitions for the SPI slave burst controller: state encoding,
// clock-polarity constants and the bit-counter width helper.
package spi_slave_ctrl_burst_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_DECODE    = 4'd2,
        ST_RD_LOAD   = 4'd3,
        ST_RD_SHIFT  = 4'd4,
        ST_RD_INC    = 4'd5,
        ST_WR_SHIFT  = 4'd6,
        ST_WR_COMMIT = 4'd7,
        ST_WR_INC    = 4'd8,
        ST_WAIT_END  = 4'd9
    } state_e;

    localparam bit CPOL_RISE = 1'b0;
    localparam bit CPOL_FALL = 1'b1;

    // Wide enough to hold the longer of the command and data phases.
    function automatic int countWidth(input int addrBits, input int dataBits);
        int longest;
        longest = (addrBits + 1 > dataBits) ? addrBits + 1 : dataBits;
        return $clog2(longest + 1);
    endfunction

endpackage

// File: rtl/spi_slave_ctrl_burst_sclk_edge_detect.sv
// One-clk sample pulse on the qualifying sclk edge; the delayed copy starts at
// the idle level so no spurious edge is seen when leaving reset.
module spi_slave_ctrl_burst_sclk_edge_detect
    import spi_slave_ctrl_burst_pkg::*;
#(
    parameter bit CPOL = CPOL_RISE
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sclk_i,
    output logic sample_o
);

    logic sclk_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sclk_q <= CPOL;
        end else begin
            sclk_q <= sclk_i;
        end
    end

    always_comb begin
        sample_o = 1'b0;
        unique case (CPOL)
            CPOL_RISE: sample_o = sclk_i & ~sclk_q;
            CPOL_FALL: sample_o = ~sclk_i & sclk_q;
        endcase
    end

endmodule

// File: rtl/spi_slave_ctrl_burst.sv
// SPI slave transaction controller: command decode, single or burst data words
// with address auto-increment, and abort reporting on early chip-select release.
module spi_slave_ctrl_burst
    import spi_slave_ctrl_burst_pkg::*;
#(
    parameter int ADDR_BITS = 7,
    parameter int DATA_BITS = 8,
    parameter bit CPOL      = 1'b0,
    parameter bit BURST_EN  = 1'b1,
    parameter bit RW_POL    = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       cs,
    input  logic       rw_bit,
    output logic       miso_buff,
    output logic       dm_we,
    output logic       addr_we,
    output logic       sr_we,
    output logic       addr_inc,
    output logic       xfer_done,
    output logic       abort,
    output logic [3:0] state_o
);

    localparam int            CW        = countWidth(ADDR_BITS, DATA_BITS);
    localparam logic [CW-1:0] CMD_LAST  = CW'(ADDR_BITS);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_BITS - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic          sample;
    logic          miso_buff_q, dm_we_q, addr_we_q, sr_we_q, addr_inc_q, xfer_done_q, abort_q;
    logic          miso_buff_d, dm_we_d, addr_we_d, sr_we_d, addr_inc_d, xfer_done_d, abort_d;

    spi_slave_ctrl_burst_sclk_edge_detect #(.CPOL(CPOL)) u_edge (
        .clk      (clk),
        .rst_n    (rst_n),
        .sclk_i   (sclk),
        .sample_o (sample)
    );

    always_comb begin
        state_d     = state_q;
        xfer_done_d = 1'b0;
        abort_d     = 1'b0;
        unique case (state_q)
            ST_IDLE:      if (!cs) state_d = ST_ADDR;
            ST_ADDR:      if (sample && count_q == CMD_LAST) state_d = ST_DECODE;
            ST_DECODE:    state_d = (rw_bit == RW_POL) ? ST_RD_LOAD : ST_WR_SHIFT;
            ST_RD_LOAD:   state_d = ST_RD_SHIFT;
            ST_RD_SHIFT: begin
                if (sample && count_q == DATA_LAST) begin
                    xfer_done_d = 1'b1;
                    state_d     = BURST_EN ? ST_RD_INC : ST_WAIT_END;
                end
            end
            ST_RD_INC:    state_d = ST_RD_LOAD;
            ST_WR_SHIFT:  if (sample && count_q == DATA_LAST) state_d = ST_WR_COMMIT;
            ST_WR_COMMIT: state_d = BURST_EN ? ST_WR_INC : ST_WAIT_END;
            ST_WR_INC:    state_d = ST_WR_SHIFT;
            ST_WAIT_END:  state_d = ST_WAIT_END;
            default:      state_d = ST_IDLE;
        endcase

        // Chip-select release wins over a coincident sample; a shift state at
        // count 0 sits on a word boundary, so leaving there is a clean end.
        if (cs && state_q != ST_IDLE) begin
            state_d     = ST_IDLE;
            xfer_done_d = 1'b0;
            abort_d     = (state_q == ST_ADDR) || (state_q == ST_DECODE) ||
                          (((state_q == ST_RD_SHIFT) || (state_q == ST_WR_SHIFT)) && count_q != '0);
        end

        if (state_d != state_q) begin
            count_d = '0;
        end else if (sample && (state_q == ST_ADDR || state_q == ST_RD_SHIFT || state_q == ST_WR_SHIFT)) begin
            count_d = count_q + 1'b1;
        end else begin
            count_d = count_q;
        end

        addr_we_d   = (state_d == ST_ADDR);
        sr_we_d     = (state_d == ST_RD_LOAD);
        dm_we_d     = (state_d == ST_WR_COMMIT);
        addr_inc_d  = (state_d == ST_RD_INC) || (state_d == ST_WR_INC);
        miso_buff_d = (state_d == ST_RD_LOAD) || (state_d == ST_RD_SHIFT) || (state_d == ST_RD_INC);
        xfer_done_d = xfer_done_d || (state_d == ST_WR_COMMIT);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            count_q     <= '0;
            miso_buff_q <= 1'b0;
            dm_we_q     <= 1'b0;
            addr_we_q   <= 1'b0;
            sr_we_q     <= 1'b0;
            addr_inc_q  <= 1'b0;
            xfer_done_q <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            miso_buff_q <= miso_buff_d;
            dm_we_q     <= dm_we_d;
            addr_we_q   <= addr_we_d;
            sr_we_q     <= sr_we_d;
            addr_inc_q  <= addr_inc_d;
            xfer_done_q <= xfer_done_d;
            abort_q     <= abort_d;
        end
    end

    assign miso_buff = miso_buff_q;
    assign dm_we     = dm_we_q;
    assign addr_we   = addr_we_q;
    assign sr_we     = sr_we_q;
    assign addr_inc  = addr_inc_q;
    assign xfer_done = xfer_done_q;
    assign abort     = abort_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_spi_slave_ctrl_burst.sv
// Scoreboard bench for spi_slave_ctrl_burst: three instances cover burst mode,
// single-word mode and CPOL=1; expected strobes and snapshots are queued by stimulus.
module tb_spi_slave_ctrl_burst;

    localparam logic [3:0] S_IDLE = 4'd0, S_ADDR = 4'd1, S_DECODE = 4'd2, S_RD_LOAD = 4'd3,
                           S_RD_SHIFT = 4'd4, S_RD_INC = 4'd5, S_WR_SHIFT = 4'd6,
                           S_WR_COMMIT = 4'd7, S_WR_INC = 4'd8, S_WAIT_END = 4'd9;

    typedef struct {
        string       name;
        logic [10:0] val;
    } expect_t;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       rwBit = 1'b0;
    logic [2:0] sclkV = 3'b100;
    logic [2:0] csV = 3'b111;
    logic [2:0] misoBuff, dmWe, addrWe, srWe, addrInc, xferDone, abortO;
    logic [3:0] stateO [3];

    int sel = 0;
    int compared = 0;
    int mismatched = 0;
    expect_t snapQ[$];
    expect_t evQ[$];

    always #5 clk = ~clk;

    // Instance 0: burst, CPOL 0.  Instance 1: single word, CPOL 0.  Instance 2: single word, CPOL 1.
    spi_slave_ctrl_burst #(.ADDR_BITS(7), .DATA_BITS(8), .CPOL(1'b0), .BURST_EN(1'b1), .RW_POL(1'b1)) dutBurst (
        .clk(clk), .rst_n(rstN), .sclk(sclkV[0]), .cs(csV[0]), .rw_bit(rwBit),
        .miso_buff(misoBuff[0]), .dm_we(dmWe[0]), .addr_we(addrWe[0]), .sr_we(srWe[0]),
        .addr_inc(addrInc[0]), .xfer_done(xferDone[0]), .abort(abortO[0]), .state_o(stateO[0]));

    spi_slave_ctrl_burst #(.ADDR_BITS(7), .DATA_BITS(8), .CPOL(1'b0), .BURST_EN(1'b0), .RW_POL(1'b1)) dutSingle (
        .clk(clk), .rst_n(rstN), .sclk(sclkV[1]), .cs(csV[1]), .rw_bit(rwBit),
        .miso_buff(misoBuff[1]), .dm_we(dmWe[1]), .addr_we(addrWe[1]), .sr_we(srWe[1]),
        .addr_inc(addrInc[1]), .xfer_done(xferDone[1]), .abort(abortO[1]), .state_o(stateO[1]));

    spi_slave_ctrl_burst #(.ADDR_BITS(7), .DATA_BITS(8), .CPOL(1'b1), .BURST_EN(1'b0), .RW_POL(1'b1)) dutCpol1 (
        .clk(clk), .rst_n(rstN), .sclk(sclkV[2]), .cs(csV[2]), .rw_bit(rwBit),
        .miso_buff(misoBuff[2]), .dm_we(dmWe[2]), .addr_we(addrWe[2]), .sr_we(srWe[2]),
        .addr_inc(addrInc[2]), .xfer_done(xferDone[2]), .abort(abortO[2]), .state_o(stateO[2]));

    function automatic logic [10:0] snap(input logic aw, input logic ms, input logic dw, input logic sw,
                                         input logic ai, input logic xd, input logic ab, input logic [3:0] st);
        return {aw, ms, dw, sw, ai, xd, ab, st};
    endfunction

    function automatic logic [10:0] ev(input logic dw, input logic sw, input logic ai,
                                       input logic xd, input logic ab, input logic [3:0] st);
        return {2'b00, dw, sw, ai, xd, ab, st};
    endfunction

    function automatic logic idleLvl();
        return (sel == 2);
    endfunction

    // Drive one clk worth of sclk/cs for the selected instance.
    task automatic applyStimulus(input logic s, input logic c);
        @(negedge clk);
        sclkV[sel] = s;
        csV[sel]   = c;
    endtask

    // Queue a full-output snapshot to be compared after the next rising clk edge.
    task automatic checkOutput(input string name, input logic [10:0] val);
        expect_t e;
        e.name = name;
        e.val  = val;
        snapQ.push_back(e);
    endtask

    task automatic expectEvent(input string name, input logic [10:0] val);
        expect_t e;
        e.name = name;
        e.val  = val;
        evQ.push_back(e);
    endtask

    task automatic sclkPulses(input int n, input logic c);
        for (int i = 0; i < n; i++) begin
            applyStimulus(~idleLvl(), c);
            applyStimulus(~idleLvl(), c);
            applyStimulus(idleLvl(), c);
            applyStimulus(idleLvl(), c);
        end
    endtask

    // Monitor: snapshots when requested, strobe events whenever any strobe fires.
    always @(posedge clk) begin
        expect_t     e;
        logic [10:0] actSnap;
        logic [10:0] actEv;
        #1;
        actSnap = {addrWe[sel], misoBuff[sel], dmWe[sel], srWe[sel], addrInc[sel],
                   xferDone[sel], abortO[sel], stateO[sel]};
        actEv   = {2'b00, dmWe[sel], srWe[sel], addrInc[sel], xferDone[sel], abortO[sel], stateO[sel]};
        if (snapQ.size() > 0) begin
            e = snapQ.pop_front();
            compared++;
            if (actSnap !== e.val) begin
                mismatched++;
                $display("[TB] FAIL snap %s: got %b, expected %b (aw,miso,dm,sr,inc,xfer,abort,state)",
                         e.name, actSnap, e.val);
            end
        end
        if (|actEv[8:4]) begin
            compared++;
            if (evQ.size() == 0) begin
                mismatched++;
                $display("[TB] FAIL event unexpected: got %b, expected no strobe", actEv[8:0]);
            end else begin
                e = evQ.pop_front();
                if (actEv !== e.val) begin
                    mismatched++;
                    $display("[TB] FAIL event %s: got %b, expected %b (dm,sr,inc,xfer,abort,state)",
                             e.name, actEv[8:0], e.val[8:0]);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        mismatched++;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            sel = i;
            checkOutput($sformatf("reset dut%0d", i), snap(0, 0, 0, 0, 0, 0, 0, S_IDLE));
        end
        @(negedge clk);
        rstN = 1'b1;

        // 1: single write, no burst
        $display("[TB] test 1: single write");
        sel = 1; rwBit = 1'b0;
        expectEvent("t1 commit", ev(1, 0, 0, 1, 0, S_WR_COMMIT));
        applyStimulus(1'b0, 1'b0);
        checkOutput("t1 enter addr", snap(1, 0, 0, 0, 0, 0, 0, S_ADDR));
        sclkPulses(7, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t1 decode", snap(0, 0, 0, 0, 0, 0, 0, S_DECODE));
        applyStimulus(1'b1, 1'b0);
        checkOutput("t1 wr_shift", snap(0, 0, 0, 0, 0, 0, 0, S_WR_SHIFT));
        applyStimulus(1'b0, 1'b0); applyStimulus(1'b0, 1'b0);
        sclkPulses(7, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t1 commit", snap(0, 0, 1, 0, 0, 1, 0, S_WR_COMMIT));
        applyStimulus(1'b1, 1'b0);
        checkOutput("t1 wait_end", snap(0, 0, 0, 0, 0, 0, 0, S_WAIT_END));
        sclkPulses(2, 1'b0);
        checkOutput("t1 still waiting", snap(0, 0, 0, 0, 0, 0, 0, S_WAIT_END));
        applyStimulus(1'b0, 1'b1);
        checkOutput("t1 cs release", snap(0, 0, 0, 0, 0, 0, 0, S_IDLE));

        // 2: single read
        $display("[TB] test 2: single read");
        rwBit = 1'b1;
        expectEvent("t2 load", ev(0, 1, 0, 0, 0, S_RD_LOAD));
        expectEvent("t2 done", ev(0, 0, 0, 1, 0, S_WAIT_END));
        applyStimulus(1'b0, 1'b0);
        sclkPulses(7, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t2 decode", snap(0, 0, 0, 0, 0, 0, 0, S_DECODE));
        applyStimulus(1'b1, 1'b0);
        checkOutput("t2 rd_load", snap(0, 1, 0, 1, 0, 0, 0, S_RD_LOAD));
        applyStimulus(1'b0, 1'b0);
        checkOutput("t2 rd_shift", snap(0, 1, 0, 0, 0, 0, 0, S_RD_SHIFT));
        applyStimulus(1'b0, 1'b0);
        sclkPulses(7, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t2 done", snap(0, 0, 0, 0, 0, 1, 0, S_WAIT_END));
        applyStimulus(1'b1, 1'b0); applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t2 cs release", snap(0, 0, 0, 0, 0, 0, 0, S_IDLE));

        // 3: burst read of three words, clean end at count 0
        $display("[TB] test 3: burst read");
        sel = 0; rwBit = 1'b1;
        expectEvent("t3 load w1", ev(0, 1, 0, 0, 0, S_RD_LOAD));
        for (int w = 1; w <= 3; w++) begin
            expectEvent($sformatf("t3 inc w%0d", w), ev(0, 0, 1, 1, 0, S_RD_INC));
            expectEvent($sformatf("t3 load w%0d", w + 1), ev(0, 1, 0, 0, 0, S_RD_LOAD));
        end
        applyStimulus(1'b0, 1'b0);
        sclkPulses(8, 1'b0);
        sclkPulses(7, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkOutput("t3 rd_inc", snap(0, 1, 0, 0, 1, 1, 0, S_RD_INC));
        applyStimulus(1'b1, 1'b0);
        checkOutput("t3 reload", snap(0, 1, 0, 1, 0, 0, 0, S_RD_LOAD));
        applyStimulus(1'b0, 1'b0); applyStimulus(1'b0, 1'b0);
        sclkPulses(16, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t3 clean end", snap(0, 0, 0, 0, 0, 0, 0, S_IDLE));

        // 4: burst write aborted mid second word
        $display("[TB] test 4: burst write abort");
        rwBit = 1'b0;
        expectEvent("t4 commit", ev(1, 0, 0, 1, 0, S_WR_COMMIT));
        expectEvent("t4 inc", ev(0, 0, 1, 0, 0, S_WR_INC));
        expectEvent("t4 abort", ev(0, 0, 0, 0, 1, S_IDLE));
        applyStimulus(1'b0, 1'b0);
        sclkPulses(19, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t4 abort", snap(0, 0, 0, 0, 0, 0, 1, S_IDLE));
        applyStimulus(1'b0, 1'b1);
        checkOutput("t4 after abort", snap(0, 0, 0, 0, 0, 0, 0, S_IDLE));

        // 5: reset mid write word
        $display("[TB] test 5: reset during write");
        applyStimulus(1'b0, 1'b0);
        sclkPulses(12, 1'b0);
        checkOutput("t5 in wr_shift", snap(0, 0, 0, 0, 0, 0, 0, S_WR_SHIFT));
        @(negedge clk);
        rstN = 1'b0;
        checkOutput("t5 reset", snap(0, 0, 0, 0, 0, 0, 0, S_IDLE));
        @(negedge clk);
        rstN = 1'b1;
        csV[sel] = 1'b1;
        sclkPulses(4, 1'b1);
        checkOutput("t5 after reset", snap(0, 0, 0, 0, 0, 0, 0, S_IDLE));

        // 6: CPOL=1, long sclk-high stretch must not advance the count
        $display("[TB] test 6: cpol1");
        sel = 2; rwBit = 1'b0;
        applyStimulus(1'b1, 1'b0);
        checkOutput("t6 enter addr", snap(1, 0, 0, 0, 0, 0, 0, S_ADDR));
        repeat (20) applyStimulus(1'b1, 1'b0);
        checkOutput("t6 held high", snap(1, 0, 0, 0, 0, 0, 0, S_ADDR));
        sclkPulses(7, 1'b0);
        checkOutput("t6 after 7 falls", snap(1, 0, 0, 0, 0, 0, 0, S_ADDR));
        applyStimulus(1'b0, 1'b0);
        checkOutput("t6 decode", snap(0, 0, 0, 0, 0, 0, 0, S_DECODE));
        applyStimulus(1'b0, 1'b0);
        checkOutput("t6 wr_shift", snap(0, 0, 0, 0, 0, 0, 0, S_WR_SHIFT));
        applyStimulus(1'b1, 1'b0); applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t6 clean end", snap(0, 0, 0, 0, 0, 0, 0, S_IDLE));

        repeat (4) @(negedge clk);
        if (evQ.size() != 0 || snapQ.size() != 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL leftover: got %0d events and %0d snapshots pending, expected 0",
                     evQ.size(), snapQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
